// File: rtl/ysyx_24100012_pc_sequencer.sv
// ysyx_24100012_pc_sequencer: multi-cycle fetch/execute sequencer that owns the PC.
// Ports: ifu_req_* fetch request, ifu_rsp_* fetch response, inst/exec_* execute
// handshake, pc_sel/branch_target/halt commit inputs, pc/retire/instret/halted/
// fault/fault_cause architectural status. All outputs come straight from flops.
module ysyx_24100012_pc_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_inst,
  input  logic                  ifu_rsp_err,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  exec_valid,
  input  logic                  exec_done,
  input  logic                  pc_sel,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic [63:0]           instret,
  output logic                  halted,
  output logic                  fault,
  output logic [1:0]            fault_cause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_FETCH = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [63:0]           instret_q, instret_d;
  logic                  retire_q, retire_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic [1:0]            cause_q, cause_d;
  logic                  req_valid_q, req_valid_d;
  logic                  rsp_ready_q, rsp_ready_d;
  logic                  exec_valid_q, exec_valid_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  tgt_misaligned;

  // pc+4 wraps naturally at the top of the address space.
  assign pc_inc         = pc_q + ADDR_WIDTH'(4);
  assign tgt_misaligned = (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    fault_d   = fault_q;
    cause_d   = cause_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_FETCH;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // ebreak retires before any target check.
          if (halt) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            retire_d  = 1'b1;
            instret_d = instret_q + 64'd1;
          end else if (pc_sel && tgt_misaligned) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_ALIGN;
          end else begin
            state_d   = S_REQ;
            pc_d      = pc_sel ? branch_target : pc_inc;
            retire_d  = 1'b1;
            instret_d = instret_q + 64'd1;
          end
        end
      end
      S_HALT, S_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state and registered,
  // so they line up with state_q without an input-to-output path.
  always_comb begin
    req_valid_d  = (state_d == S_REQ);
    rsp_ready_d  = (state_d == S_RSP);
    exec_valid_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      instret_q    <= '0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      req_valid_q  <= 1'b0;
      rsp_ready_q  <= 1'b0;
      exec_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      instret_q    <= instret_d;
      retire_q     <= retire_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      req_valid_q  <= req_valid_d;
      rsp_ready_q  <= rsp_ready_d;
      exec_valid_q <= exec_valid_d;
    end
  end

  assign ifu_req_valid = req_valid_q;
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = rsp_ready_q;
  assign inst          = inst_q;
  assign exec_valid    = exec_valid_q;
  assign pc            = pc_q;
  assign retire        = retire_q;
  assign instret       = instret_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;

endmodule
